fetch_pc_stage: RTL

//  Parametrised fetch-stage PC register, successor to the fixed 64-bit predicted-PC latch.
//  - Holds the PC for the next fetch and selects it from three sources: the predicted PC,
//    an M-stage mispredict correction, or a W-stage return address.
//  - Adds reset vector, stall/bubble control, a halt state, a valid flag and saturating

---
 rtl/fetch_pc_stage_pkg.sv | 6 +
 rtl/fetch_pc_stage_sat_counter.sv | 17 +
 rtl/fetch_pc_stage.sv | 73 +++++++
 3 files changed

// File: rtl/fetch_pc_stage_pkg.sv
// fetch_pc_stage_pkg: shared fetch-stage state encoding and PC defaults.
package fetch_pc_stage_pkg;
    typedef enum logic [1:0] {RUN, RECOVER, HALTED} state_t;
    localparam int          PC_W_DEF     = 64;
    localparam logic [63:0] RESET_PC_DEF = 64'h0;
endpackage

// File: rtl/fetch_pc_stage_sat_counter.sv
// sat_counter: event counter that sticks at all-ones and can be frozen.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (inc && !freeze && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
    assign cnt_o = r_cnt;
endmodule

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage: registered fetch PC with redirect/stall/bubble selection,
// halt state, valid flag and saturating stall/redirect counters.
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             bubble_i,
    input  logic             halt_i,
    input  logic [PC_W-1:0]  pred_pc_i,
    input  logic             redir_m_i,
    input  logic [PC_W-1:0]  redir_m_pc_i,
    input  logic             redir_w_i,
    input  logic [PC_W-1:0]  redir_w_pc_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             pc_valid_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] redir_cnt_o
);
    state_t          r_state, w_next;
    logic [PC_W-1:0] r_pc, w_pc;
    logic            r_valid, w_valid;
    logic            w_halted, w_redir, w_stall;
    assign w_halted = r_state == HALTED;
    assign w_redir  = !w_halted && !halt_i && (redir_m_i || redir_w_i);
    // A redirect in the same cycle swallows the stall, so it is not counted.
    assign w_stall  = !w_halted && !halt_i && !redir_m_i && !redir_w_i && stall_i;
    always_comb begin
        w_next  = r_state;
        w_pc    = r_pc;
        w_valid = r_valid;
        if (w_halted) begin
            w_next = HALTED;
        end else if (halt_i) begin
            w_next  = HALTED;
            w_valid = 1'b0;
        end else if (w_redir) begin
            w_next  = RECOVER;
            w_pc    = redir_m_i ? redir_m_pc_i : redir_w_pc_i;
            w_valid = 1'b1;
        end else begin
            w_next  = RUN;
            w_pc    = (stall_i || bubble_i) ? r_pc : pred_pc_i;
            w_valid = stall_i ? r_valid : !bubble_i;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_valid <= 1'b1;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc;
            r_valid <= w_valid;
        end
    end
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .inc(w_stall), .freeze(w_halted), .cnt_o(stall_cnt_o)
    );
    sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
        .clk(clk), .rst(rst), .inc(w_redir), .freeze(w_halted), .cnt_o(redir_cnt_o)
    );
    assign pc_o       = r_pc;
    assign pc_valid_o = r_valid;
    assign halted_o   = w_halted;
endmodule
